// File: rtl/timer_counter_if.sv
// Bridge-side register bus for the DEV_TC timer/counter.
// The master drives the write strobe, address and data. The slave returns read data and irq.
interface timer_counter_if #(parameter int ADDR_WD = 8);
    logic               we;
    logic [ADDR_WD-1:0] addr;
    logic [31:0]        wd;
    logic [31:0]        rd;
    logic               irq;

    modport master (output we, addr, wd, input rd, irq);
    modport slave  (input we, addr, wd, output rd, irq);
endinterface

// File: rtl/timer_counter.sv
// DEV_TC memory-mapped down-counter with one-shot and auto-reload modes, plus a level irq.
// Optional macro TC_COUNT_WR_EN makes COUNT (0x08) writable.
module timer_counter #(
    parameter int ADDR_WD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_counter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state, state_nxt;
    logic        en, im;
    logic [1:0]  mode;
    logic [31:0] preset, count, count_nxt;
    logic        en_clr;

    logic [ADDR_WD-3:0] word;
    logic               wr_ctrl, wr_preset, auto_rl, run;
    logic               unused_addr_lsb;

    assign word            = bus.addr[ADDR_WD-1:2];
    assign unused_addr_lsb = ^bus.addr[1:0];
    assign wr_ctrl         = bus.we && (word == (ADDR_WD-2)'(0));
    assign wr_preset       = bus.we && (word == (ADDR_WD-2)'(1));
    assign auto_rl         = (mode == 2'b01);
    // A CTRL write in the same cycle overrides the registered EN, so a stop request is never lost.
    assign run             = wr_ctrl ? bus.wd[0] : en;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        en_clr    = 1'b0;
        case (state)
            S_IDLE: if (en) state_nxt = S_LOAD;
            S_LOAD: begin
                count_nxt = preset;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!run)
                    state_nxt = S_IDLE;
                else if (count != 32'd0)
                    count_nxt = count - 32'd1;
                else begin
                    state_nxt = S_INT;
                    en_clr    = !auto_rl;
                end
            end
            S_INT: begin
                if (auto_rl)
                    state_nxt = S_LOAD;
                else if (wr_ctrl)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
`ifdef TC_COUNT_WR_EN
        if (bus.we && (word == (ADDR_WD-2)'(2)))
            count_nxt = bus.wd;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            preset <= '0;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (wr_preset)
                preset <= bus.wd;
            if (wr_ctrl) begin
                en   <= bus.wd[0];
                mode <= bus.wd[2:1];
                im   <= bus.wd[3];
            end else if (en_clr) begin
                en <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        case (word)
            (ADDR_WD-2)'(0): bus.rd = {28'd0, im, mode, en};
            (ADDR_WD-2)'(1): bus.rd = preset;
            (ADDR_WD-2)'(2): bus.rd = count;
            default:         bus.rd = '0;
        endcase
    end

    assign bus.irq = (state == S_INT) && im;

endmodule

// File: tb/tb_timer_counter.sv
// Randomized scenario bench for timer_counter.
// Expected COUNT and irq come from closed-form timing derived from the register and timing rules.
module tb_timer_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    timer_counter_if #(.ADDR_WD(8)) bus();
    timer_counter #(.ADDR_WD(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Reference: cycles after the EN-writing edge E (k=1 is LOAD).
    function automatic int ref_oneshot_count(int p, int k);
        if (k <= 1) return -1;
        if (k <= p + 2) return p - (k - 2);
        return 0;
    endfunction

    function automatic int ref_auto_count(int p, int k);
        int pos;
        pos = (k - 1) % (p + 3);
        if (pos == 0) return (k == 1) ? -1 : 0;
        if (pos <= p + 1) return p - (pos - 1);
        return 0;
    endfunction

    function automatic logic ref_auto_irq(int p, int k, logic im);
        return im && (((k - 1) % (p + 3)) == p + 2);
    endfunction

    task automatic do_reset();
        bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns 1 time unit after the commit edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.addr = a; bus.wd = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rd;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        foreach (v[i]) v[i] = 1'b1;
        for (int a = 0; a < 12; a += 4) begin
            rd_reg(8'(a), v);
            n_chk++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL reset_rd addr=%0h got=%0h exp=0", a, v); end
        end
        n_chk++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_regs();
        logic [31:0] v, r;
        do_reset();
        r = $urandom;
        wr(8'h04, r);
        rd_reg(8'h04, v); n_chk++;
        if (v !== r) begin n_fail++; $display("FAIL preset_rd got=%0h exp=%0h", v, r); end
        rd_reg(8'h07, v); n_chk++;
        if (v !== r) begin n_fail++; $display("FAIL preset_rd_lsb got=%0h exp=%0h", v, r); end
        wr(8'h10, 32'hDEAD_BEEF);
        rd_reg(8'h10, v); n_chk++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_rd got=%0h exp=0", v); end
        rd_reg(8'h0C, v); n_chk++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL rd_0c got=%0h exp=0", v); end
        rd_reg(8'h04, v); n_chk++;
        if (v !== r) begin n_fail++; $display("FAIL preset_after_unmapped got=%0h exp=%0h", v, r); end
        wr(8'h00, 32'hFFFF_FFF6);
        rd_reg(8'h00, v); n_chk++;
        if (v !== 32'h6) begin n_fail++; $display("FAIL ctrl_rd got=%0h exp=6", v); end
    endtask

    task automatic test_oneshot(input int p, input logic im);
        logic [31:0] v;
        int          e;
        do_reset();
        wr(8'h04, 32'(p));
        wr(8'h00, im ? 32'h9 : 32'h1);
        for (int k = 1; k <= p + 8; k++) begin
            step();
            rd_reg(8'h08, v);
            e = ref_oneshot_count(p, k);
            if (e >= 0) begin
                n_chk++;
                if (v !== 32'(e)) begin n_fail++; $display("FAIL oneshot_count p=%0d k=%0d got=%0h exp=%0h", p, k, v, e); end
            end
            n_chk++;
            if (bus.irq !== (im && k >= p + 3)) begin
                n_fail++; $display("FAIL oneshot_irq p=%0d k=%0d got=%b exp=%b", p, k, bus.irq, im && k >= p + 3);
            end
        end
        repeat (10) step();
        rd_reg(8'h00, v); n_chk++;
        if (v !== (im ? 32'h8 : 32'h0)) begin n_fail++; $display("FAIL oneshot_ctrl got=%0h exp=%0h", v, im ? 8 : 0); end
        n_chk++;
        if (bus.irq !== im) begin n_fail++; $display("FAIL oneshot_irq_hold got=%b exp=%b", bus.irq, im); end
        wr(8'h00, 32'h0);
        n_chk++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear got=%b exp=0", bus.irq); end
    endtask

    task automatic test_autoreload(input int p, input logic im);
        logic [31:0] v;
        int          e, pulses;
        do_reset();
        pulses = 0;
        wr(8'h04, 32'(p));
        wr(8'h00, im ? 32'hB : 32'h3);
        for (int k = 1; k <= 3 * (p + 3) + 1; k++) begin
            step();
            rd_reg(8'h08, v);
            e = ref_auto_count(p, k);
            if (e >= 0) begin
                n_chk++;
                if (v !== 32'(e)) begin n_fail++; $display("FAIL auto_count p=%0d k=%0d got=%0h exp=%0h", p, k, v, e); end
            end
            if (bus.irq === 1'b1) pulses++;
            n_chk++;
            if (bus.irq !== ref_auto_irq(p, k, im)) begin
                n_fail++; $display("FAIL auto_irq p=%0d k=%0d got=%b exp=%b", p, k, bus.irq, ref_auto_irq(p, k, im));
            end
        end
        n_chk++;
        if (pulses !== (im ? 3 : 0)) begin n_fail++; $display("FAIL auto_pulses got=%0d exp=%0d", pulses, im ? 3 : 0); end
    endtask

    task automatic test_pause();
        logic [31:0] v;
        int          p, x;
        do_reset();
        p = $urandom_range(12, 24);
        x = $urandom_range(3, p - 2);
        wr(8'h04, 32'(p));
        wr(8'h00, 32'h1);
        repeat (2 + p - x) step();
        rd_reg(8'h08, v); n_chk++;
        if (v !== 32'(x)) begin n_fail++; $display("FAIL pause_pre got=%0h exp=%0h", v, x); end
        wr(8'h00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            rd_reg(8'h08, v); n_chk++;
            if (v !== 32'(x)) begin n_fail++; $display("FAIL pause_hold i=%0d got=%0h exp=%0h", i, v, x); end
            step();
        end
        wr(8'h00, 32'h1);
        step();
        rd_reg(8'h08, v); n_chk++;
        if (v !== 32'(x)) begin n_fail++; $display("FAIL pause_load_cycle got=%0h exp=%0h", v, x); end
        step();
        rd_reg(8'h08, v); n_chk++;
        if (v !== 32'(p)) begin n_fail++; $display("FAIL pause_reload got=%0h exp=%0h", v, p); end
    endtask

    task automatic test_preset_change();
        logic [31:0] v;
        int          p, q, e, j;
        do_reset();
        p = $urandom_range(4, 10);
        q = $urandom_range(0, 6);
        wr(8'h04, 32'(p));
        wr(8'h00, 32'h3);
        repeat (3) step();
        wr(8'h04, 32'(q));
        for (int k = 4; k <= p + 5 + q; k++) begin
            if (k <= p + 2) e = p - (k - 2);
            else if (k <= p + 4) e = 0;
            else begin j = k - (p + 5); e = (j <= q) ? q - j : 0; end
            rd_reg(8'h08, v); n_chk++;
            if (v !== 32'(e)) begin n_fail++; $display("FAIL preset_change p=%0d q=%0d k=%0d got=%0h exp=%0h", p, q, k, v, e); end
            step();
        end
    endtask

    task automatic test_stop_at_zero();
        logic [31:0] v;
        int          p;
        do_reset();
        p = $urandom_range(1, 6);
        wr(8'h04, 32'(p));
        wr(8'h00, 32'h9);
        repeat (p + 2) step();
        rd_reg(8'h08, v); n_chk++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL stopzero_pre got=%0h exp=0", v); end
        wr(8'h00, 32'h8);
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL stopzero_irq i=%0d got=%b exp=0", i, bus.irq); end
            step();
        end
        rd_reg(8'h00, v); n_chk++;
        if (v !== 32'h8) begin n_fail++; $display("FAIL stopzero_ctrl got=%0h exp=8", v); end
    endtask

    task automatic test_count_write();
        logic [31:0] v, e;
        do_reset();
        wr(8'h04, 32'h20);
        wr(8'h00, 32'h1);
        repeat (4) step();
        wr(8'h08, 32'h55);
        for (int i = 0; i < 3; i++) begin
`ifdef TC_COUNT_WR_EN
            e = 32'h55 - 32'(i);
`else
            e = 32'h20 - 32'(3 + i);
`endif
            rd_reg(8'h08, v); n_chk++;
            if (v !== e) begin n_fail++; $display("FAIL count_write i=%0d got=%0h exp=%0h", i, v, e); end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        int          p;
        do_reset();
        p = $urandom_range(5, 10);
        wr(8'h04, 32'(p));
        wr(8'h00, 32'h9);
        repeat (3) step();
        #1 rst_n = 1'b0;
        for (int a = 0; a < 12; a += 4) begin
            rd_reg(8'(a), v); n_chk++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL arst_count_rd addr=%0h got=%0h exp=0", a, v); end
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) step();
        rd_reg(8'h08, v); n_chk++;
        if (v !== 32'd0 || bus.irq !== 1'b0) begin n_fail++; $display("FAIL arst_idle count=%0h irq=%b exp=0/0", v, bus.irq); end
        wr(8'h04, 32'd2);
        wr(8'h00, 32'h9);
        repeat (5) step();
        n_chk++;
        if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL arst_int_reach got=%b exp=1", bus.irq); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL arst_int_irq got=%b exp=0", bus.irq); end
        rd_reg(8'h00, v); n_chk++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL arst_int_ctrl got=%0h exp=0", v); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();
        n_chk++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL arst_post_irq got=%b exp=0", bus.irq); end
        p = $urandom_range(1, 30);
        wr(8'h04, 32'(p));
        wr(8'h00, 32'h1);
        repeat (2) step();
        rd_reg(8'h08, v); n_chk++;
        if (v !== 32'(p)) begin n_fail++; $display("FAIL arst_restart got=%0h exp=%0h", v, p); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_oneshot(3, 1'b1);
        test_oneshot(0, 1'b1);
        test_oneshot($urandom_range(1, 6), 1'b0);
        repeat (2) test_oneshot($urandom_range(1, 8), 1'b1);
        test_autoreload(2, 1'b1);
        test_autoreload(2, 1'b0);
        test_autoreload(0, 1'b1);
        test_autoreload($urandom_range(1, 6), 1'b1);
        repeat (2) test_pause();
        repeat (2) test_preset_change();
        repeat (2) test_stop_at_zero();
        test_count_write();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
